conv_window_gen: RTL

//  Upstream feeder for the subkernel MAC stage. Accepts a raster-order pixel stream,

---
 rtl/cnn_pkg.sv | 24 ++
 rtl/conv_window_gen_line_buffer.sv | 37 +++
 rtl/conv_window_gen.sv | 139 +++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared definitions for the convolution window front end: default geometry,
// counter widths, window FSM encoding and the window element index helper.
package cnn_pkg;

   localparam int IN_BIT_SIZE_D   = 8;
   localparam int KERNEL_WIDTH_D  = 4;
   localparam int KERNEL_HEIGHT_D = 3;
   localparam int IMG_WIDTH_D     = 28;
   localparam int IMG_HEIGHT_D    = 28;
   localparam int ROW_W_D         = $clog2(IMG_HEIGHT_D);
   localparam int COL_W_D         = $clog2(IMG_WIDTH_D);

   typedef enum logic [1:0] {
      ST_ACCEPT = 2'd0,
      ST_RUN    = 2'd1,
      ST_CLEAR  = 2'd2
   } win_state_e;

   // Flat element index of window row r, column c (row-major, top-left is 0).
   function automatic int win_idx(input int r, input int c, input int kw);
      return r * kw + c;
   endfunction

endpackage

// File: rtl/conv_window_gen_line_buffer.sv
// Circular delay line: dout is the sample written DEPTH enabled cycles earlier.
module line_buffer #(
   parameter int W     = 8,
   parameter int DEPTH = 28
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

   logic [W-1:0]  mem_r [DEPTH];
   logic [PW-1:0] ptr_r;

   // Storage write; contents need no reset since they are overwritten before use.
   always_ff @(posedge clk) begin
      if (en) begin
         mem_r[ptr_r] <= din;
      end
   end

   // Write/read pointer advances once per enabled cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_r <= '0;
      end else if (en) begin
         ptr_r <= (ptr_r == PTR_LAST) ? '0 : ptr_r + PW'(1);
      end
   end

   // Read happens before this cycle's write lands, giving a full DEPTH delay.
   assign dout = mem_r[ptr_r];

endmodule

// File: rtl/conv_window_gen.sv
// Raster pixel stream to KERNEL_HEIGHT x KERNEL_WIDTH sliding window, handshaking
// each valid window through the subkernel start/done/clear sequence.
module conv_window_gen #(
   parameter int IN_BIT_SIZE   = 8,
   parameter int KERNEL_WIDTH  = 4,
   parameter int KERNEL_HEIGHT = 3,
   parameter int IMG_WIDTH     = 28,
   parameter int IMG_HEIGHT    = 28
) (
   input  logic                                           clk,
   input  logic                                           reset,
   input  logic [IN_BIT_SIZE-1:0]                         pix_in,
   input  logic                                           pix_valid,
   output logic                                           pix_ready,
   output logic [KERNEL_WIDTH*KERNEL_HEIGHT*IN_BIT_SIZE-1:0] X,
   output logic                                           sub_start,
   output logic                                           sub_clear,
   input  logic                                           sub_done,
   output logic [$clog2(IMG_HEIGHT)-1:0]                  win_row,
   output logic [$clog2(IMG_WIDTH)-1:0]                   win_col,
   output logic                                           frame_done
);
   import cnn_pkg::*;

   localparam int ROW_W = $clog2(IMG_HEIGHT);
   localparam int COL_W = $clog2(IMG_WIDTH);
   localparam int XW    = KERNEL_WIDTH * KERNEL_HEIGHT * IN_BIT_SIZE;
   localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(KERNEL_HEIGHT - 1);
   localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);
   localparam logic [COL_W-1:0] COL_FIRST = COL_W'(KERNEL_WIDTH - 1);
   localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_WIDTH - 1);

   win_state_e       state_r;
   logic [ROW_W-1:0] row_r;
   logic [COL_W-1:0] col_r;
   logic             last_r;
   logic [XW-1:0]    win_next_s;
   logic             accept_s;
   logic             win_valid_s;
   logic             last_px_s;
   logic [IN_BIT_SIZE-1:0] tap_s [KERNEL_HEIGHT];

   assign accept_s    = pix_valid & pix_ready;
   assign win_valid_s = (row_r >= ROW_FIRST) && (col_r >= COL_FIRST);
   assign last_px_s   = (row_r == ROW_LAST) && (col_r == COL_LAST);

   // tap_s[k] is the input stream delayed by k full lines.
   assign tap_s[0] = pix_in;
   for (genvar g = 0; g < KERNEL_HEIGHT - 1; g++) begin : g_lb
      line_buffer #(
         .W     (IN_BIT_SIZE),
         .DEPTH (IMG_WIDTH)
      ) u_lb (
         .clk   (clk),
         .reset (reset),
         .en    (accept_s),
         .din   (tap_s[g]),
         .dout  (tap_s[g+1])
      );
   end

   // Next window: shift each row left, feed the rightmost column from the taps.
   always_comb begin
      win_next_s = X;
      for (int r = 0; r < KERNEL_HEIGHT; r++) begin
         for (int c = 0; c < KERNEL_WIDTH - 1; c++) begin
            win_next_s[win_idx(r, c, KERNEL_WIDTH)*IN_BIT_SIZE +: IN_BIT_SIZE] =
               X[win_idx(r, c + 1, KERNEL_WIDTH)*IN_BIT_SIZE +: IN_BIT_SIZE];
         end
         win_next_s[win_idx(r, KERNEL_WIDTH - 1, KERNEL_WIDTH)*IN_BIT_SIZE +: IN_BIT_SIZE] =
            tap_s[KERNEL_HEIGHT - 1 - r];
      end
   end

   // Window FSM, raster counters and all registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r    <= ST_ACCEPT;
         row_r      <= '0;
         col_r      <= '0;
         last_r     <= 1'b0;
         X          <= '0;
         win_row    <= '0;
         win_col    <= '0;
         pix_ready  <= 1'b1;
         sub_start  <= 1'b0;
         sub_clear  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         case (state_r)
            ST_ACCEPT: begin
               sub_clear  <= 1'b0;
               frame_done <= 1'b0;
               if (accept_s) begin
                  X <= win_next_s;
                  // The final pixel wraps straight to (0,0) so the next frame needs no gap.
                  if (col_r == COL_LAST) begin
                     col_r <= '0;
                     row_r <= (row_r == ROW_LAST) ? '0 : row_r + ROW_W'(1);
                  end else begin
                     col_r <= col_r + COL_W'(1);
                  end
                  if (win_valid_s) begin
                     state_r   <= ST_RUN;
                     pix_ready <= 1'b0;
                     sub_start <= 1'b1;
                     win_row   <= row_r - ROW_FIRST;
                     win_col   <= col_r - COL_FIRST;
                     last_r    <= last_px_s;
                  end
               end
            end
            ST_RUN: begin
               if (sub_done) begin
                  state_r    <= ST_CLEAR;
                  sub_start  <= 1'b0;
                  sub_clear  <= 1'b1;
                  frame_done <= last_r;
               end
            end
            ST_CLEAR: begin
               state_r    <= ST_ACCEPT;
               sub_clear  <= 1'b0;
               frame_done <= 1'b0;
               pix_ready  <= 1'b1;
               last_r     <= 1'b0;
            end
            default: begin
               state_r    <= ST_ACCEPT;
               pix_ready  <= 1'b1;
               sub_start  <= 1'b0;
               sub_clear  <= 1'b0;
               frame_done <= 1'b0;
            end
         endcase
      end
   end

endmodule
